// File: rtl/uart_word_rx_ctrl.sv
// uart_word_rx_ctrl: pairs UART bytes into 16-bit words {high, low} and
// presents them on a valid/ready handshake.
// Errors are flagged with sticky bits. A bad byte in IDLE or HIGH
// resynchronises the pairing by going back to IDLE.
// Optional feature macro: WORD_TIMEOUT_EN. When it is defined, a low byte
// whose high byte does not arrive within TIMEOUT_CYCLES clocks is dropped.
module uart_word_rx_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_ferror,
  input  logic        rx_perror,
  input  logic        word_ready,
  input  logic        err_clr,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        busy,
  output logic        error,
  output logic        overrun,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  low_q, low_d;
  logic [15:0] word_q, word_d;
  logic        error_q, error_d;
  logic        overrun_q, overrun_d;
  logic        err_set, ovr_set, to_set;
  logic        good_strobe, bad_strobe;

  assign good_strobe = rx_valid & ~rx_ferror & ~rx_perror;
  assign bad_strobe  = rx_valid & (rx_ferror | rx_perror);

`ifdef WORD_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  // Next-state, datapath and flag-set logic for the pairing FSM
  always_comb begin
    state_d = state_q;
    low_d   = low_q;
    word_d  = word_q;
    err_set = 1'b0;
    ovr_set = 1'b0;
    to_set  = 1'b0;
`ifdef WORD_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (good_strobe) begin
          low_d   = rx_data;
          state_d = ST_HIGH;
        end else if (bad_strobe) begin
          err_set = 1'b1;
        end
      end
      ST_HIGH: begin
        if (good_strobe) begin
          word_d  = {rx_data, low_q};
          state_d = ST_HOLD;
        end else if (bad_strobe) begin
          // Discard the partial word and resynchronise.
          err_set = 1'b1;
          low_d   = 8'h00;
          state_d = ST_IDLE;
        end
`ifdef WORD_TIMEOUT_EN
        // A strobe on the expiry cycle was handled above and wins.
        else if (cnt_q == TO_LAST) begin
          to_set  = 1'b1;
          low_d   = 8'h00;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_HOLD: begin
        if (bad_strobe) begin
          err_set = 1'b1;
        end
        if (word_ready) begin
          if (good_strobe) begin
            // The held word is consumed and this byte starts the next word.
            low_d   = rx_data;
            state_d = ST_HIGH;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (good_strobe) begin
          ovr_set = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef WORD_TIMEOUT_EN
    // The counter restarts every time HIGH is entered.
    if (state_d == ST_HIGH && state_q != ST_HIGH) begin
      cnt_d = '0;
    end
`endif
    // When a set and a clear arrive together, the set wins.
    error_d   = (error_q & ~err_clr) | err_set;
    overrun_d = (overrun_q & ~err_clr) | ovr_set;
  end

  // FSM state, byte latch, word register and sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      low_q     <= 8'h00;
      word_q    <= 16'h0000;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      low_q     <= low_d;
      word_q    <= word_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef WORD_TIMEOUT_EN
  // Timeout counter and sticky timeout flag
  always_comb begin
    timeout_d = (timeout_q & ~err_clr) | to_set;
  end

  // Timeout counter and sticky timeout flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // The timeout parameters have no effect in this build. The comparison is
  // always false, so timeout stays tied low. It only references the
  // parameters so they are not reported as unused.
  assign timeout = to_set & (TIMEOUT_CYCLES < 0) & (TO_W < 0);
`endif

  assign word_out   = word_q;
  assign word_valid = (state_q == ST_HOLD);
  assign busy       = (state_q != ST_IDLE);
  assign error      = error_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_word_rx_ctrl.sv
// Testbench for uart_word_rx_ctrl: a table of per-cycle vectors, plus
// hand-written sequences for async reset and the timeout behaviour.
module tb_uart_word_rx_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferror;
  logic        rx_perror;
  logic        word_ready;
  logic        err_clr;
  logic [15:0] word_out;
  logic        word_valid;
  logic        busy;
  logic        error;
  logic        overrun;
  logic        timeout;

  int total;
  int bad;

  uart_word_rx_ctrl #(
    .TIMEOUT_CYCLES(10),
    .TO_W          (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ferror (rx_ferror),
    .rx_perror (rx_perror),
    .word_ready(word_ready),
    .err_clr   (err_clr),
    .word_out  (word_out),
    .word_valid(word_valid),
    .busy      (busy),
    .error     (error),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        fe;
    logic        pe;
    logic        rdy;
    logic        clr;
    logic [15:0] w;
    logic        wv;
    logic        bsy;
    logic        er;
    logic        ov;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic v, logic [7:0] d, logic fe, logic pe,
                              logic rdy, logic clr, logic [15:0] w,
                              logic wv, logic bsy, logic er, logic ov);
    vec_t r;
    r.v = v; r.d = d; r.fe = fe; r.pe = pe; r.rdy = rdy; r.clr = clr;
    r.w = w; r.wv = wv; r.bsy = bsy; r.er = er; r.ov = ov;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] w, input logic wv,
                           input logic bsy, input logic er, input logic ov, input logic to);
    check({tag, ".word_out"},   word_out,          w);
    check({tag, ".word_valid"}, {15'd0, word_valid}, {15'd0, wv});
    check({tag, ".busy"},       {15'd0, busy},     {15'd0, bsy});
    check({tag, ".error"},      {15'd0, error},    {15'd0, er});
    check({tag, ".overrun"},    {15'd0, overrun},  {15'd0, ov});
    check({tag, ".timeout"},    {15'd0, timeout},  {15'd0, to});
  endtask

  // Drive one cycle of inputs at the falling edge. Outputs are sampled
  // later, 1 ns after the rising edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic fe,
                       input logic pe, input logic rdy, input logic clr);
    @(negedge clk);
    rx_valid = v; rx_data = d; rx_ferror = fe; rx_perror = pe;
    word_ready = rdy; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rx_valid = 1'b0; rx_data = 8'h00; rx_ferror = 1'b0; rx_perror = 1'b0;
    word_ready = 1'b0; err_clr = 1'b0;
    reset = 1'b1;

    //             v  data  fe pe rdy clr  word     wv bsy er ov
    // 1: 34,12 -> 1234, then consumed
    vecs[0]  = mk(1, 8'h34, 0, 0, 1, 0, 16'h0000, 0, 1, 0, 0);
    vecs[1]  = mk(1, 8'h12, 0, 0, 1, 0, 16'h1234, 1, 1, 0, 0);
    vecs[2]  = mk(0, 8'h00, 0, 0, 1, 0, 16'h1234, 0, 0, 0, 0);
    // 2: parity error in HIGH resyncs, then 22,11 -> 1122
    vecs[3]  = mk(1, 8'h01, 0, 0, 0, 0, 16'h1234, 0, 1, 0, 0);
    vecs[4]  = mk(1, 8'hAA, 0, 1, 0, 0, 16'h1234, 0, 0, 1, 0);
    vecs[5]  = mk(1, 8'h22, 0, 0, 0, 0, 16'h1234, 0, 1, 1, 0);
    vecs[6]  = mk(1, 8'h11, 0, 0, 0, 0, 16'h1122, 1, 1, 1, 0);
    vecs[7]  = mk(0, 8'h00, 0, 0, 1, 0, 16'h1122, 0, 0, 1, 0);
    vecs[8]  = mk(0, 8'h00, 0, 0, 0, 1, 16'h1122, 0, 0, 0, 0);
    // 3: hold BEEF, overrun, clear, set-wins-over-clear
    vecs[9]  = mk(1, 8'hEF, 0, 0, 0, 0, 16'h1122, 0, 1, 0, 0);
    vecs[10] = mk(1, 8'hBE, 0, 0, 0, 0, 16'hBEEF, 1, 1, 0, 0);
    vecs[11] = mk(1, 8'h55, 0, 0, 0, 0, 16'hBEEF, 1, 1, 0, 1);
    vecs[12] = mk(0, 8'h00, 0, 0, 0, 0, 16'hBEEF, 1, 1, 0, 1);
    vecs[13] = mk(0, 8'h00, 0, 0, 0, 1, 16'hBEEF, 1, 1, 0, 0);
    vecs[14] = mk(1, 8'h56, 0, 0, 0, 1, 16'hBEEF, 1, 1, 0, 1);
    vecs[15] = mk(0, 8'h00, 0, 0, 0, 1, 16'hBEEF, 1, 1, 0, 0);
    vecs[16] = mk(1, 8'h57, 1, 0, 0, 0, 16'hBEEF, 1, 1, 1, 0);
    // 4: ready coincident with strobe 77, then 66 -> 6677
    vecs[17] = mk(1, 8'h77, 0, 0, 1, 0, 16'hBEEF, 0, 1, 1, 0);
    vecs[18] = mk(1, 8'h66, 0, 0, 0, 0, 16'h6677, 1, 1, 1, 0);
    vecs[19] = mk(1, 8'h99, 0, 1, 1, 0, 16'h6677, 0, 0, 1, 0);
    vecs[20] = mk(0, 8'h00, 0, 0, 0, 1, 16'h6677, 0, 0, 0, 0);

    // Reset state
    #1 reset = 1'b0;
    #1;
    check_all("reset", 16'h0000, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].fe, vecs[i].pe, vecs[i].rdy, vecs[i].clr);
      check_all($sformatf("v%0d", i), vecs[i].w, vecs[i].wv, vecs[i].bsy,
                vecs[i].er, vecs[i].ov, 1'b0);
      $display("vec %0d: word_out=%h word_valid=%b busy=%b error=%b overrun=%b",
               i, word_out, word_valid, busy, error, overrun);
    end

    // 6: async reset while in HIGH; strobes during reset are ignored
    drive(1, 8'h42, 0, 0, 0, 0);
    check_all("rst.pre", 16'h6677, 0, 1, 0, 0, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_all("rst.now", 16'h0000, 0, 0, 0, 0, 0);
    rx_valid = 1'b1; rx_data = 8'h99;
    @(posedge clk);
    #1;
    check_all("rst.strobe", 16'h0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b1;
    drive(1, 8'h0D, 0, 0, 0, 0);
    check_all("rst.low", 16'h0000, 0, 1, 0, 0, 0);
    drive(1, 8'hF0, 0, 0, 0, 0);
    check_all("rst.word", 16'hF00D, 1, 1, 0, 0, 0);
    $display("reset seq: word_out=%h word_valid=%b", word_out, word_valid);
    drive(0, 8'h00, 0, 0, 1, 0);
    check_all("rst.done", 16'hF00D, 0, 0, 0, 0, 0);

    // 5: missing high byte
    drive(1, 8'h5A, 0, 0, 0, 0);
`ifdef WORD_TIMEOUT_EN
    repeat (9) drive(0, 8'h00, 0, 0, 0, 0);
    check_all("to.pre", 16'hF00D, 0, 1, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0, 0);
    check_all("to.exp", 16'hF00D, 0, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 0, 0, 1);
    check_all("to.clr", 16'hF00D, 0, 0, 0, 0, 0);
`else
    repeat (20) drive(0, 8'h00, 0, 0, 0, 0);
    check_all("to.wait", 16'hF00D, 0, 1, 0, 0, 0);
    drive(1, 8'hC3, 0, 0, 0, 0);
    check_all("to.late", 16'hC35A, 1, 1, 0, 0, 0);
`endif
    $display("timeout seq: busy=%b timeout=%b", busy, timeout);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
